// File: rtl/mux_ndff_tx.sv
// Source-side sender for the mux/n-flop synchronizer: holds a word on data_hold,
// raises req, and runs a four-phase handshake against a locally synchronized ack.
module mux_ndff_tx #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 256,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  input  logic             ack_async,
  output logic             req,
  output logic [DW-1:0]    data_hold,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int TW_RAW = $clog2(TIMEOUT + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  logic [DW-1:0]          data_q, data_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;

  // ack_async crosses into clk here and nowhere else
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_async};
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    timer_d = timer_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          req_d   = 1'b1;
          timer_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        timer_d = timer_q + TW'(1);
        // ack wins a same-cycle tie with the timeout
        if (ack_s) begin
          req_d   = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_DROP;
        end else if ((TIMEOUT != 0) && (timer_q == T_LAST)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (!ack_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
  end

  assign req       = req_q;
  assign data_hold = data_q;
  assign err       = err_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_mux_ndff_tx.sv
// Directed bench for mux_ndff_tx with DW=8, SYNC_STAGES=2, TIMEOUT=8, CNT_W=4.
module tb_mux_ndff_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       ack_async;
  logic       req;
  logic [7:0] data_hold;
  logic       busy;
  logic       err;
  logic [3:0] xfer_cnt;

  int errors = 0;
  int checks = 0;

  mux_ndff_tx #(
    .DW(8), .SYNC_STAGES(2), .TIMEOUT(8), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ack_async(ack_async), .req(req),
    .data_hold(data_hold), .busy(busy), .err(err), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick(1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; ack_async = 1'b0;
    tick(1);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_data", 32'(data_hold), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnt", 32'(xfer_cnt), 32'd0);
    rst = 1'b0;

    // basic transfer, ack raised 4 cycles after accept
    accept(8'hA5);
    chk("b_req_up", 32'(req), 32'd1);
    chk("b_data", 32'(data_hold), 32'hA5);
    chk("b_ready", 32'(in_ready), 32'd0);
    chk("b_busy", 32'(busy), 32'd1);
    tick(4);
    chk("b_req_hold", 32'(req), 32'd1);
    ack_async = 1'b1;
    tick(2);
    chk("b_req_edge2", 32'(req), 32'd1);
    tick(1);
    chk("b_req_fall", 32'(req), 32'd0);
    chk("b_cnt", 32'(xfer_cnt), 32'd1);
    chk("b_drop_busy", 32'(busy), 32'd1);
    ack_async = 1'b0;
    tick(2);
    chk("b_drop_ready", 32'(in_ready), 32'd0);
    tick(1);
    chk("b_idle", 32'(in_ready), 32'd1);
    chk("b_err", 32'(err), 32'd0);
    chk("b_data_kept", 32'(data_hold), 32'hA5);

    // stability: in_valid held high, in_data changing during REQ/DROP
    in_valid = 1'b1;
    in_data  = 8'h01;
    tick(1);
    ack_async = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      in_data = 8'(k + 1);
      tick(1);
      chk("s_data", 32'(data_hold), 32'h01);
      chk("s_req", 32'(req), (k <= 2) ? 32'd1 : 32'd0);
      chk("s_ready", 32'(in_ready), (k == 6) ? 32'd1 : 32'd0);
      if (k == 3) ack_async = 1'b0;
    end
    in_data = 8'h08;
    tick(1);
    in_valid = 1'b0;
    chk("s_next_data", 32'(data_hold), 32'h08);
    chk("s_next_req", 32'(req), 32'd1);
    chk("s_cnt", 32'(xfer_cnt), 32'd2);
    ack_async = 1'b1;
    tick(3);
    chk("s_cnt2", 32'(xfer_cnt), 32'd3);
    ack_async = 1'b0;
    tick(3);
    chk("s_idle", 32'(in_ready), 32'd1);

    // timeout with ack never raised
    accept(8'h3C);
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      chk("t_req_high", 32'(req), 32'd1);
    end
    tick(1);
    chk("t_req_low", 32'(req), 32'd0);
    chk("t_err", 32'(err), 32'd1);
    chk("t_cnt", 32'(xfer_cnt), 32'd3);
    chk("t_drop", 32'(in_ready), 32'd0);
    tick(1);
    chk("t_idle", 32'(in_ready), 32'd1);
    chk("t_data", 32'(data_hold), 32'h3C);
    accept(8'h5A);
    ack_async = 1'b1;
    tick(3);
    chk("t2_req_low", 32'(req), 32'd0);
    chk("t2_cnt", 32'(xfer_cnt), 32'd4);
    ack_async = 1'b0;
    tick(3);
    chk("t2_idle", 32'(in_ready), 32'd1);
    chk("t2_err_sticky", 32'(err), 32'd1);

    // late ack: synchronized ack rises just after the abort
    accept(8'hC3);
    tick(6);
    ack_async = 1'b1;
    tick(2);
    chk("l_req_low", 32'(req), 32'd0);
    chk("l_cnt", 32'(xfer_cnt), 32'd4);
    tick(3);
    chk("l_drop_hold", 32'(in_ready), 32'd0);
    ack_async = 1'b0;
    tick(2);
    chk("l_drop_edge2", 32'(in_ready), 32'd0);
    tick(1);
    chk("l_idle", 32'(in_ready), 32'd1);
    chk("l_cnt2", 32'(xfer_cnt), 32'd4);

    // ack and timeout in the same cycle
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("x_err_clr", 32'(err), 32'd0);
    chk("x_cnt_clr", 32'(xfer_cnt), 32'd0);
    accept(8'h11);
    tick(5);
    ack_async = 1'b1;
    tick(2);
    chk("x_req_pre", 32'(req), 32'd1);
    tick(1);
    chk("x_req_low", 32'(req), 32'd0);
    chk("x_cnt", 32'(xfer_cnt), 32'd1);
    chk("x_err", 32'(err), 32'd0);
    ack_async = 1'b0;
    tick(3);
    chk("x_idle", 32'(in_ready), 32'd1);

    // reset mid-REQ with a simultaneous accept attempt
    accept(8'h22);
    tick(2);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h77;
    tick(1);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("r_req", 32'(req), 32'd0);
    chk("r_data", 32'(data_hold), 32'd0);
    chk("r_cnt", 32'(xfer_cnt), 32'd0);
    chk("r_ready", 32'(in_ready), 32'd1);
    chk("r_busy", 32'(busy), 32'd0);

    // 17 transfers wrap the 4-bit counter back to 1
    for (int i = 0; i < 17; i++) begin
      accept(8'(i));
      ack_async = 1'b1;
      tick(3);
      chk("w_req_low", 32'(req), 32'd0);
      chk("w_cnt", 32'(xfer_cnt), 32'((i + 1) % 16));
      ack_async = 1'b0;
      tick(3);
      chk("w_idle", 32'(in_ready), 32'd1);
    end
    chk("w_final", 32'(xfer_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
